alink_dev: RTL and testbench

ALINK_DEV -- requirements
Module: alink_dev

---
 rtl/alink_dev.sv | 232 +++++++++++++++++++++++
 tb/tb_alink_dev.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alink_dev.sv
// Two-wire pulse link endpoint: deserializes RX_P/RX_N pulses into 32-bit task words
// and serializes 32-bit report words onto TX_P/TX_N.
module alink_dev #(
   parameter int unsigned BIT_W   = 4,
   parameter int unsigned GAP_W   = 4,
   parameter int unsigned RX_TOUT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RX_P,
   input  logic        RX_N,
   output logic        task_vld,
   input  logic        task_rdy,
   output logic [31:0] task_dat,
   input  logic        rpt_vld,
   output logic        rpt_rdy,
   input  logic [31:0] rpt_dat,
   output logic        TX_P,
   output logic        TX_N,
   output logic        rx_err,
   input  logic        err_clr
);

   localparam int unsigned WORD_W = 32;
   localparam int unsigned IDX_W  = 5;
   localparam int unsigned TMAX   = (BIT_W > GAP_W) ? BIT_W : GAP_W;
   localparam int unsigned TCNT_W = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam int unsigned TOUT_W = (RX_TOUT > 1) ? $clog2(RX_TOUT) : 1;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_PULSE = 2'd1,
      TX_GAP   = 2'd2
   } tx_state_e;

   // ---------------- receiver ----------------
   logic p_meta_q, p_sync_q, p_hist_q;
   logic n_meta_q, n_sync_q, n_hist_q;

   logic [WORD_W-2:0] shift_q, shift_d;
   logic [IDX_W-1:0]  bcnt_q, bcnt_d;
   logic [TOUT_W-1:0] tout_q, tout_d;
   logic              block_q, block_d;
   logic              task_vld_q, task_vld_d;
   logic [WORD_W-1:0] task_dat_q, task_dat_d;
   logic              rx_err_q, rx_err_d;

   logic              p_rise, n_rise, both_hi, err_set;
   logic [WORD_W-1:0] word;

   // Two-flop synchronizers plus history flop for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_meta_q <= 1'b0;
         p_sync_q <= 1'b0;
         p_hist_q <= 1'b0;
         n_meta_q <= 1'b0;
         n_sync_q <= 1'b0;
         n_hist_q <= 1'b0;
      end else begin
         p_meta_q <= RX_P;
         p_sync_q <= p_meta_q;
         p_hist_q <= p_sync_q;
         n_meta_q <= RX_N;
         n_sync_q <= n_meta_q;
         n_hist_q <= n_sync_q;
      end
   end

   assign p_rise  = p_sync_q & ~p_hist_q;
   assign n_rise  = n_sync_q & ~n_hist_q;
   assign both_hi = p_sync_q & n_sync_q;
   assign word    = {shift_q, p_rise};

   always_comb begin
      shift_d    = shift_q;
      bcnt_d     = bcnt_q;
      tout_d     = tout_q;
      block_d    = block_q;
      task_vld_d = task_vld_q;
      task_dat_d = task_dat_q;
      rx_err_d   = rx_err_q;
      err_set    = 1'b0;

      if (task_vld_q && task_rdy) begin
         task_vld_d = 1'b0;
      end
      if (err_clr) begin
         rx_err_d = 1'b0;
      end

      if (both_hi) begin
         err_set = 1'b1;
         shift_d = '0;
         bcnt_d  = '0;
         tout_d  = '0;
         block_d = 1'b1;
      end else if (block_q) begin
         // Stay deaf until both lines have returned low
         if (!p_sync_q && !n_sync_q) begin
            block_d = 1'b0;
         end
      end else if (p_rise || n_rise) begin
         tout_d = '0;
         if (bcnt_q == IDX_W'(WORD_W - 1)) begin
            bcnt_d  = '0;
            shift_d = '0;
            if (!task_vld_q || task_rdy) begin
               task_vld_d = 1'b1;
               task_dat_d = word;
            end else begin
               err_set = 1'b1;
            end
         end else begin
            bcnt_d  = bcnt_q + IDX_W'(1);
            shift_d = word[WORD_W-2:0];
         end
      end else if (bcnt_q != '0) begin
         // Silent line with a partial word: discard it after RX_TOUT cycles
         if (tout_q == TOUT_W'(RX_TOUT - 1)) begin
            bcnt_d  = '0;
            shift_d = '0;
            tout_d  = '0;
         end else begin
            tout_d = tout_q + TOUT_W'(1);
         end
      end else begin
         tout_d = '0;
      end

      if (err_set) begin
         rx_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q    <= '0;
         bcnt_q     <= '0;
         tout_q     <= '0;
         block_q    <= 1'b0;
         task_vld_q <= 1'b0;
         task_dat_q <= '0;
         rx_err_q   <= 1'b0;
      end else begin
         shift_q    <= shift_d;
         bcnt_q     <= bcnt_d;
         tout_q     <= tout_d;
         block_q    <= block_d;
         task_vld_q <= task_vld_d;
         task_dat_q <= task_dat_d;
         rx_err_q   <= rx_err_d;
      end
   end

   assign task_vld = task_vld_q;
   assign task_dat = task_dat_q;
   assign rx_err   = rx_err_q;

   // ---------------- transmitter ----------------
   tx_state_e         tx_state_q;
   logic [WORD_W-2:0] tx_sh_q;
   logic [IDX_W-1:0]  tx_idx_q;
   logic [TCNT_W-1:0] tx_cnt_q;
   logic              tx_p_q, tx_n_q, rpt_rdy_q;

   // Pulse/gap serializer, MSB first; line registers follow the state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state_q <= TX_IDLE;
         tx_sh_q    <= '0;
         tx_idx_q   <= '0;
         tx_cnt_q   <= '0;
         tx_p_q     <= 1'b0;
         tx_n_q     <= 1'b0;
         rpt_rdy_q  <= 1'b0;
      end else begin
         case (tx_state_q)
            TX_IDLE: begin
               rpt_rdy_q <= 1'b1;
               if (rpt_vld && rpt_rdy_q) begin
                  rpt_rdy_q  <= 1'b0;
                  tx_sh_q    <= rpt_dat[WORD_W-2:0];
                  tx_idx_q   <= IDX_W'(WORD_W - 1);
                  tx_cnt_q   <= '0;
                  tx_p_q     <= rpt_dat[WORD_W-1];
                  tx_n_q     <= ~rpt_dat[WORD_W-1];
                  tx_state_q <= TX_PULSE;
               end
            end
            TX_PULSE: begin
               if (tx_cnt_q == TCNT_W'(BIT_W - 1)) begin
                  tx_p_q     <= 1'b0;
                  tx_n_q     <= 1'b0;
                  tx_cnt_q   <= '0;
                  tx_state_q <= TX_GAP;
               end else begin
                  tx_cnt_q <= tx_cnt_q + TCNT_W'(1);
               end
            end
            TX_GAP: begin
               if (tx_cnt_q == TCNT_W'(GAP_W - 1)) begin
                  tx_cnt_q <= '0;
                  if (tx_idx_q == '0) begin
                     rpt_rdy_q  <= 1'b1;
                     tx_state_q <= TX_IDLE;
                  end else begin
                     tx_idx_q   <= tx_idx_q - IDX_W'(1);
                     tx_sh_q    <= {tx_sh_q[WORD_W-3:0], 1'b0};
                     tx_p_q     <= tx_sh_q[WORD_W-2];
                     tx_n_q     <= ~tx_sh_q[WORD_W-2];
                     tx_state_q <= TX_PULSE;
                  end
               end else begin
                  tx_cnt_q <= tx_cnt_q + TCNT_W'(1);
               end
            end
            default: begin
               tx_p_q     <= 1'b0;
               tx_n_q     <= 1'b0;
               tx_cnt_q   <= '0;
               tx_state_q <= TX_IDLE;
            end
         endcase
      end
   end

   assign rpt_rdy = rpt_rdy_q;
   assign TX_P    = tx_p_q;
   assign TX_N    = tx_n_q;

endmodule

// File: tb/tb_alink_dev.sv
// Directed bench for alink_dev: receive path, transmit waveform, overflow,
// timeout, line-collision error and mid-word reset.
module tb_alink_dev;

   localparam int unsigned BIT_W   = 4;
   localparam int unsigned GAP_W   = 4;
   localparam int unsigned RX_TOUT = 64;
   localparam int unsigned PER     = BIT_W + GAP_W;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        RX_P = 1'b0;
   logic        RX_N = 1'b0;
   logic        task_vld;
   logic        task_rdy = 1'b0;
   logic [31:0] task_dat;
   logic        rpt_vld = 1'b0;
   logic        rpt_rdy;
   logic [31:0] rpt_dat = 32'h0;
   logic        TX_P;
   logic        TX_N;
   logic        rx_err;
   logic        err_clr = 1'b0;

   int total = 0;
   int bad = 0;

   logic [31:0] acc_q[$];
   int          vld_cycles = 0;

   alink_dev #(.BIT_W(BIT_W), .GAP_W(GAP_W), .RX_TOUT(RX_TOUT)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .RX_P    (RX_P),
      .RX_N    (RX_N),
      .task_vld(task_vld),
      .task_rdy(task_rdy),
      .task_dat(task_dat),
      .rpt_vld (rpt_vld),
      .rpt_rdy (rpt_rdy),
      .rpt_dat (rpt_dat),
      .TX_P    (TX_P),
      .TX_N    (TX_N),
      .rx_err  (rx_err),
      .err_clr (err_clr)
   );

   always #5 clk = ~clk;

   // Record accepted words and cycles with task_vld high
   always @(posedge clk) begin
      if (task_vld === 1'b1) vld_cycles++;
      if (task_vld === 1'b1 && task_rdy === 1'b1) acc_q.push_back(task_dat);
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic rx_bit(input logic b);
      if (b) RX_P = 1'b1;
      else   RX_N = 1'b1;
      cyc(BIT_W);
      RX_P = 1'b0;
      RX_N = 1'b0;
      cyc(GAP_W);
   endtask

   task automatic rx_word(input logic [31:0] w);
      for (int i = 31; i >= 0; i--) rx_bit(w[i]);
   endtask

   task automatic test_reset;
      cyc(3);
      total++; if (task_vld !== 1'b0) begin bad++; $display("FAIL reset_task_vld: got %b exp 0", task_vld); end
      total++; if (task_dat !== 32'h0) begin bad++; $display("FAIL reset_task_dat: got %h exp 00000000", task_dat); end
      total++; if (rpt_rdy !== 1'b0) begin bad++; $display("FAIL reset_rpt_rdy: got %b exp 0", rpt_rdy); end
      total++; if (TX_P !== 1'b0 || TX_N !== 1'b0) begin bad++; $display("FAIL reset_tx: got P=%b N=%b exp 0 0", TX_P, TX_N); end
      total++; if (rx_err !== 1'b0) begin bad++; $display("FAIL reset_rx_err: got %b exp 0", rx_err); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++; if (rpt_rdy !== 1'b1) begin bad++; $display("FAIL reset_rpt_rdy_rise: got %b exp 1", rpt_rdy); end
      @(negedge clk);
   endtask

   task automatic test_rx_word;
      task_rdy = 1'b1;
      acc_q.delete();
      vld_cycles = 0;
      rx_word(32'hA5C3_0F81);
      cyc(10);
      total++; if (acc_q.size() !== 1) begin bad++; $display("FAIL rx_word_count: got %0d exp 1", acc_q.size()); end
      else begin
         total++; if (acc_q[0] !== 32'hA5C3_0F81) begin bad++; $display("FAIL rx_word_data: got %h exp a5c30f81", acc_q[0]); end
      end
      total++; if (vld_cycles !== 1) begin bad++; $display("FAIL rx_word_vld_cycles: got %0d exp 1", vld_cycles); end
      total++; if (rx_err !== 1'b0) begin bad++; $display("FAIL rx_word_err: got %b exp 0", rx_err); end
   endtask

   task automatic test_tx_word;
      int   errs;
      logic exp_p, exp_n;
      errs = 0;
      total++; if (rpt_rdy !== 1'b1) begin bad++; $display("FAIL tx_rdy_idle: got %b exp 1", rpt_rdy); end
      rpt_vld = 1'b1;
      rpt_dat = 32'h8000_0001;
      @(negedge clk);
      rpt_vld = 1'b0;
      for (int k = 0; k < 32 * PER; k++) begin
         exp_p = ((k % PER) < BIT_W) && ((k / PER) == 0 || (k / PER) == 31);
         exp_n = ((k % PER) < BIT_W) && !((k / PER) == 0 || (k / PER) == 31);
         if (TX_P !== exp_p || TX_N !== exp_n || rpt_rdy !== 1'b0) begin
            if (errs < 4)
               $display("FAIL tx_wave: cycle %0d got P=%b N=%b rdy=%b exp P=%b N=%b rdy=0",
                        k, TX_P, TX_N, rpt_rdy, exp_p, exp_n);
            errs++;
         end
         @(negedge clk);
      end
      total++; if (errs !== 0) begin bad++; $display("FAIL tx_wave_total: got %0d bad cycles exp 0", errs); end
      total++; if (rpt_rdy !== 1'b1) begin bad++; $display("FAIL tx_rdy_return: got %b exp 1 after 256 cycles", rpt_rdy); end
      total++; if (TX_P !== 1'b0 || TX_N !== 1'b0) begin bad++; $display("FAIL tx_idle_lines: got P=%b N=%b exp 0 0", TX_P, TX_N); end
   endtask

   task automatic test_overflow;
      task_rdy = 1'b0;
      acc_q.delete();
      rx_word(32'h1111_2222);
      cyc(10);
      total++; if (task_vld !== 1'b1) begin bad++; $display("FAIL ovf_first_vld: got %b exp 1", task_vld); end
      total++; if (rx_err !== 1'b0) begin bad++; $display("FAIL ovf_first_err: got %b exp 0", rx_err); end
      rx_word(32'h3333_4444);
      cyc(10);
      total++; if (task_vld !== 1'b1) begin bad++; $display("FAIL ovf_held_vld: got %b exp 1", task_vld); end
      total++; if (task_dat !== 32'h1111_2222) begin bad++; $display("FAIL ovf_held_dat: got %h exp 11112222", task_dat); end
      total++; if (rx_err !== 1'b1) begin bad++; $display("FAIL ovf_err_set: got %b exp 1", rx_err); end
      err_clr = 1'b1;
      cyc(1);
      err_clr = 1'b0;
      total++; if (rx_err !== 1'b0) begin bad++; $display("FAIL ovf_err_clr: got %b exp 0", rx_err); end
      task_rdy = 1'b1;
      cyc(1);
      total++; if (acc_q.size() !== 1) begin bad++; $display("FAIL ovf_accept_count: got %0d exp 1", acc_q.size()); end
      else begin
         total++; if (acc_q[0] !== 32'h1111_2222) begin bad++; $display("FAIL ovf_accept_dat: got %h exp 11112222", acc_q[0]); end
      end
      total++; if (task_vld !== 1'b0) begin bad++; $display("FAIL ovf_vld_drop: got %b exp 0", task_vld); end
   endtask

   task automatic test_timeout;
      task_rdy = 1'b1;
      acc_q.delete();
      for (int i = 0; i < 10; i++) rx_bit(1'b1);
      cyc(RX_TOUT + 16);
      rx_word(32'h1234_5678);
      cyc(10);
      total++; if (acc_q.size() !== 1) begin bad++; $display("FAIL tout_count: got %0d exp 1", acc_q.size()); end
      else begin
         total++; if (acc_q[0] !== 32'h1234_5678) begin bad++; $display("FAIL tout_dat: got %h exp 12345678", acc_q[0]); end
      end
      total++; if (rx_err !== 1'b0) begin bad++; $display("FAIL tout_err: got %b exp 0", rx_err); end
   endtask

   task automatic test_both_high;
      task_rdy = 1'b1;
      acc_q.delete();
      vld_cycles = 0;
      rx_bit(1'b0); rx_bit(1'b1); rx_bit(1'b0); rx_bit(1'b1); rx_bit(1'b1);
      RX_P = 1'b1;
      RX_N = 1'b1;
      err_clr = 1'b1;
      cyc(6);
      total++; if (rx_err !== 1'b1) begin bad++; $display("FAIL both_set_wins: got %b exp 1", rx_err); end
      RX_P = 1'b0;
      RX_N = 1'b0;
      err_clr = 1'b0;
      cyc(6);
      total++; if (rx_err !== 1'b1) begin bad++; $display("FAIL both_sticky: got %b exp 1", rx_err); end
      err_clr = 1'b1;
      cyc(1);
      err_clr = 1'b0;
      total++; if (rx_err !== 1'b0) begin bad++; $display("FAIL both_clr: got %b exp 0", rx_err); end
      rx_word(32'hDEAD_BEEF);
      cyc(10);
      total++; if (acc_q.size() !== 1) begin bad++; $display("FAIL both_count: got %0d exp 1", acc_q.size()); end
      else begin
         total++; if (acc_q[0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL both_dat: got %h exp deadbeef", acc_q[0]); end
      end
      total++; if (rx_err !== 1'b0) begin bad++; $display("FAIL both_after_err: got %b exp 0", rx_err); end
   endtask

   task automatic test_reset_mid;
      task_rdy = 1'b1;
      acc_q.delete();
      rpt_vld = 1'b1;
      rpt_dat = 32'hFFFF_FFFF;
      cyc(1);
      rpt_vld = 1'b0;
      // Transmitter runs while 12 bits are received
      for (int i = 0; i < 12; i++) rx_bit(1'b1);
      total++; if (TX_P !== 1'b1 || TX_N !== 1'b0) begin bad++; $display("FAIL mid_tx_active: got P=%b N=%b exp 1 0", TX_P, TX_N); end
      rst_n = 1'b0;
      #1;
      total++; if (TX_P !== 1'b0 || TX_N !== 1'b0) begin bad++; $display("FAIL mid_rst_tx: got P=%b N=%b exp 0 0", TX_P, TX_N); end
      total++; if (rpt_rdy !== 1'b0 || task_vld !== 1'b0) begin bad++; $display("FAIL mid_rst_flags: got rdy=%b vld=%b exp 0 0", rpt_rdy, task_vld); end
      cyc(3);
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++; if (rpt_rdy !== 1'b1) begin bad++; $display("FAIL mid_rdy_rise: got %b exp 1", rpt_rdy); end
      vld_cycles = 0;
      cyc(100);
      total++; if (vld_cycles !== 0) begin bad++; $display("FAIL mid_no_vld: got %0d vld cycles exp 0", vld_cycles); end
      total++; if (TX_P !== 1'b0 || TX_N !== 1'b0) begin bad++; $display("FAIL mid_tx_idle: got P=%b N=%b exp 0 0", TX_P, TX_N); end
      total++; if (acc_q.size() !== 0) begin bad++; $display("FAIL mid_no_word: got %0d words exp 0", acc_q.size()); end
   endtask

   initial begin
      test_reset;
      test_rx_word;
      test_tx_word;
      test_overflow;
      test_timeout;
      test_both_high;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
